mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port 8x32 memory (sync write, async read) between N_REQ requesters.
- Each requester issues one read or write with a req/ack handshake. The arbiter latches the winner's command and drives the memory port for exactly one cycle.
- It returns read data on a shared bus, qualified by a one-hot ack pulse.
- Sits between CPU/DMA-style masters and the memory instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 3, memory address width (8 words)
- DATA_W, 32, data word width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request, level; held until own ack seen
- we  in  N_REQ  per-requester op: 1 write, 0 read; stable while req high
- addr  in  N_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_REQ*DATA_W  flattened write data; requester i at [i*DATA_W +: DATA_W]
- ack  out  N_REQ  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  read data; valid in the ack cycle of a read
- busy  out  1  high when state != IDLE
- grant_id  out  $clog2(N_REQ)  index of current/last granted requester
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory async read data

Behaviour:
- States: IDLE, ACCESS, DONE. Encoding is free.
- Reset (async, immediate) values:
  - state = IDLE; ack = 0; rdata = 0; busy = 0; grant_id = 0.
  - last_grant = N_REQ-1, so requester 0 wins first.
  - Command latches cleared to 0.
  - mem_we = 0 combinationally from state, so no write occurs during reset.
- IDLE:
  - If req != 0, round-robin from (last_grant+1) mod N_REQ picks winner w.
  - At the same edge: latch we[w], addr[w], wdata[w]; grant_id <= w; last_grant <= w; go to ACCESS.
  - If req == 0, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr; mem_wdata = latched data; mem_we = latched we.
  - The memory performs the write at the edge ending ACCESS.
  - At that edge: if read, rdata <= mem_rdata; if write, rdata holds its previous value. ack[w] <= 1; go to DONE.
- DONE (1 cycle):
  - ack[w] = 1; every other ack bit = 0.
  - All req bits are ignored in this cycle; the granted requester drops or changes req here.
  - Next edge: ack <= 0, go to IDLE.
- Outside ACCESS: mem_we = 0; mem_addr/mem_wdata hold the latched values.
- Latency: req seen at edge k (state IDLE) -> ack high during cycle k+2 -> earliest next grant at edge k+3. Throughput is 1 access per 3 cycles.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,...; no requester waits more than N_REQ grants.
- Requests arriving while busy are not lost; they are evaluated at the next IDLE edge.
- Reset mid-operation: reset asserted in ACCESS before the edge -> no memory write, no ack, last_grant reset. The requester must reissue.
- Read of an address just written: the read transaction observes the new value (the write completed 3+ cycles earlier).
- Address width is fixed by the memory: no wrap logic; all 8 addresses are valid.

Test Plan:
- Single write then read: req[0], we=1, addr=3, wdata=0xDEADBEEF -> mem_we high for exactly one cycle 1 cycle after grant, ack[0] pulse 2 cycles after grant edge. Then a read of addr=3 -> rdata=0xDEADBEEF with ack[0].
- Simultaneous contention: req=4'b1111, all reads at addr=i -> grant_id sequence 0,1,2,3; acks 0001,0010,0100,1000 every 3 cycles; rdata = preloaded mem[i].
- Round-robin after skip: last_grant=1, req=4'b0011 -> requester 0 is granted before 1 again. Requester 2 asserting later is granted before 1's second turn.
- Request while busy: req[2] rises during ACCESS of requester 0 -> req[2] is granted at the first IDLE edge, ack[2] 3 cycles after ack[0].
- Reset in ACCESS: write addr=5, wdata=0x12345678; assert reset mid-ACCESS -> mem_we drops immediately, mem[5] unchanged, ack=0, busy=0, next grant goes to requester 0.
- Write-only rdata hold: read addr=1 (0xAAAA0001), then write addr=2 -> rdata stays 0xAAAA0001 through the write's ack cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Round-robin arbiter and sequencer that shares one single-port memory
// (synchronous write, asynchronous read) between N_REQ requesters. Each
// transaction takes three cycles: IDLE (grant + command latch), ACCESS (the
// memory port is driven for exactly one cycle) and DONE (one-hot ack pulse,
// read data valid).
//
// Handshake: a requester raises req[i] with we[i]/addr[i]/wdata[i] stable and
// holds it until it sees ack[i] high. ack[i] is a single-cycle pulse; during
// that cycle all req bits are ignored, so the requester may drop req or
// present a new command. rdata is valid in the ack cycle of a read and holds
// its value across writes.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   req        per-requester level request
//   we         per-requester op: 1 write, 0 read
//   addr       flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata      flattened write data, requester i at [i*DATA_W +: DATA_W]
//   ack        one-hot completion pulse
//   rdata      read data of the most recent read
//   busy       high whenever the sequencer is not idle
//   grant_id   index of the current / last granted requester
//   mem_we     memory write enable (only ever high in ACCESS)
//   mem_addr   memory address (latched command)
//   mem_wdata  memory write data (latched command)
//   mem_rdata  memory asynchronous read data
module mem_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     last_grant;
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    // Round-robin pick: scan priority offsets 0..N_REQ-1 starting one past
    // the last winner; the first requesting index at the lowest offset wins.
    // Both loop bounds are constants, so every select below is static.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int off = 0; off < N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!win_found && req[i] &&
                    (i == (int'(last_grant) + 1 + off) % N_REQ)) begin
                    win_found = 1'b1;
                    win_id    = ID_W'(i);
                    win_we    = we[i];
                    win_addr  = addr[i*ADDR_W +: ADDR_W];
                    win_wdata = wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs. mem_we is derived from state so
    // an asynchronous reset in ACCESS kills the write immediately.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (win_found) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_we    = cmd_we;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, grant bookkeeping, ack pulse and read data capture.
    // last_grant resets to N_REQ-1 so requester 0 has first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= ID_W'(N_REQ - 1);
            grant_id   <= '0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            ack        <= '0;
            rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        last_grant <= win_id;
                        grant_id   <= win_id;
                        cmd_we     <= win_we;
                        cmd_addr   <= win_addr;
                        cmd_wdata  <= win_wdata;
                    end
                end
                ACCESS: begin
                    if (!cmd_we) begin
                        rdata <= mem_rdata;
                    end
                    ack <= N_REQ'(1) << grant_id;
                end
                DONE: begin
                    ack <= '0;
                end
                default: begin
                    ack <= '0;
                end
            endcase
        end
    end

    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Holds the 8x32 memory instance, a
// transaction-level model (grant time, round-robin pointer, reference memory)
// that predicts every output on every cycle, and queues of hand-computed read
// data and grant order checked at each ack.
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int IW = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      ack;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .grant_id  (grant_id),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory instance ----------------
    logic [DW-1:0] mem [8];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // ---------------- scoreboard state ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [DW-1:0] exp_q[$];
    int            grant_q[$];
    int            ack_cyc[N];
    int            we_cnt = 0;
    bit            chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    // A grant at edge g means: ACCESS after edge g, DONE after edge g+1,
    // idle again after g+2, earliest next grant at edge g+3.
    int            cyc = 0;
    int            m_last_g = -100;
    int            m_rr = N - 1;
    int            m_w = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] ref_mem [8];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_last_g = -100;
            m_rr     = N - 1;
            m_w      = 0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            m_rdata  = '0;
        end else begin
            cyc++;
            if (cyc == m_last_g + 1) begin
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      m_rdata = ref_mem[m_addr];
            end
            if (cyc >= m_last_g + 3 && req != 0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (((req >> c) & 4'd1) != 0) begin
                        m_w      = c;
                        m_rr     = c;
                        m_last_g = cyc;
                        m_we     = ((we >> c) & 4'd1) != 0;
                        m_addr   = AW'(addr >> (c * AW));
                        m_wdata  = DW'(wdata >> (c * DW));
                        break;
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        int d;
        #1;
        if (!reset && chk_en) begin
            d = cyc - m_last_g;
            chk("busy",      32'(busy),      32'(d == 0 || d == 1));
            chk("mem_we",    32'(mem_we),    32'(d == 0 && m_we));
            chk("mem_addr",  32'(mem_addr),  32'(m_addr));
            chk("mem_wdata", mem_wdata,      m_wdata);
            chk("ack",       32'(ack),       (d == 1) ? (32'd1 << m_w) : 32'd0);
            chk("rdata",     rdata,          m_rdata);
            chk("grant_id",  32'(grant_id),  32'(m_w));
            if (mem_we) we_cnt++;
            if (ack != 0) begin
                for (int i = 0; i < N; i++) if (ack[i]) ack_cyc[i] = cyc;
                if (grant_q.size() == 0) begin
                    chk("grant_order_empty", 32'(grant_id), 32'hFFFF_FFFF);
                end else begin
                    chk("grant_order", 32'(grant_id), 32'(grant_q.pop_front()));
                end
                if (!m_we) begin
                    if (exp_q.size() == 0) chk("read_data_empty", rdata, 32'hFFFF_FFFF);
                    else                   chk("read_data", rdata, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Advance to the next falling edge; a requester drops req once it sees ack.
    task automatic tick();
        @(negedge clk);
        req = req & ~ack;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
        req[i]             = 1'b1;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        tick();
        while ((req != 0 || busy || ack != 0) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk("wait_quiet_timeout", 32'(req), 32'd0);
    endtask

    task automatic wait_req_clear(input int i);
        int n;
        n = 0;
        while ((req[i] || ack[i]) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk("wait_req_clear_timeout", 32'(i), 32'hFFFF_FFFF);
    endtask

    task automatic issue(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        tick();
        set_req(i, w, a, d);
        wait_quiet();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int we_before;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 32'hAAAA_0000 + 32'(i);
            ref_mem[i] = 32'hAAAA_0000 + 32'(i);
        end
        reset = 1'b1;
        #1;
        chk("reset_ack",      32'(ack),      32'd0);
        chk("reset_rdata",    rdata,         32'd0);
        chk("reset_busy",     32'(busy),     32'd0);
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        chk("reset_mem_we",   32'(mem_we),   32'd0);
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Contention from reset: grants 0,1,2,3, one every 3 cycles.
        tick();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0);
        exp_q.push_back(32'hAAAA_0000); exp_q.push_back(32'hAAAA_0001);
        exp_q.push_back(32'hAAAA_0002); exp_q.push_back(32'hAAAA_0003);
        grant_q.push_back(0); grant_q.push_back(1);
        grant_q.push_back(2); grant_q.push_back(3);
        wait_quiet();
        chk("contend_gap_01", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
        chk("contend_gap_23", 32'(ack_cyc[3] - ack_cyc[2]), 32'd3);

        // Single write then read back.
        we_before = we_cnt;
        grant_q.push_back(0);
        issue(0, 1'b1, 3'd3, 32'hDEAD_BEEF);
        chk("write_one_cycle", 32'(we_cnt - we_before), 32'd1);
        chk("write_mem3",      mem[3],                  32'hDEAD_BEEF);
        grant_q.push_back(0);
        exp_q.push_back(32'hDEAD_BEEF);
        issue(0, 1'b0, 3'd3, '0);

        // Round robin after skip: last grant 1, then 0 and 1 together,
        // 2 arrives late and beats 1's second turn.
        grant_q.push_back(1);
        exp_q.push_back(32'hAAAA_0007);
        issue(1, 1'b0, 3'd7, '0);
        grant_q.push_back(0); grant_q.push_back(1);
        grant_q.push_back(2); grant_q.push_back(1);
        exp_q.push_back(32'hAAAA_0004); exp_q.push_back(32'hAAAA_0005);
        exp_q.push_back(32'hAAAA_0006); exp_q.push_back(32'hDEAD_BEEF);
        tick();
        set_req(0, 1'b0, 3'd4, '0);
        set_req(1, 1'b0, 3'd5, '0);
        repeat (4) tick();
        set_req(2, 1'b0, 3'd6, '0);
        wait_req_clear(1);
        set_req(1, 1'b0, 3'd3, '0);
        wait_quiet();

        // Request arriving during ACCESS of another requester.
        grant_q.push_back(0); grant_q.push_back(2);
        exp_q.push_back(32'hAAAA_0000); exp_q.push_back(32'hAAAA_0002);
        tick();
        set_req(0, 1'b0, 3'd0, '0);
        tick();
        set_req(2, 1'b0, 3'd2, '0);
        wait_quiet();
        chk("busy_req_gap", 32'(ack_cyc[2] - ack_cyc[0]), 32'd3);

        // rdata holds through a write's ack cycle.
        grant_q.push_back(1);
        exp_q.push_back(32'hAAAA_0001);
        issue(1, 1'b0, 3'd1, '0);
        grant_q.push_back(3);
        issue(3, 1'b1, 3'd2, 32'h5555_AAAA);
        chk("rdata_hold", rdata, 32'hAAAA_0001);
        chk("write_mem2", mem[2], 32'h5555_AAAA);

        // Reset in the middle of ACCESS of a write.
        tick();
        set_req(2, 1'b1, 3'd5, 32'h1234_5678);
        tick();
        chk("rst_pre_mem_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_ack",    32'(ack),    32'd0);
        req = '0;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_mem5", mem[5], 32'hAAAA_0005);
        grant_q.push_back(0); grant_q.push_back(3);
        exp_q.push_back(32'hAAAA_0005); exp_q.push_back(32'h5555_AAAA);
        tick();
        set_req(3, 1'b0, 3'd2, '0);
        set_req(0, 1'b0, 3'd5, '0);
        wait_quiet();

        // Final state of the shared memory and leftover expectations.
        for (int i = 0; i < 8; i++) chk("final_mem", mem[i], ref_mem[i]);
        chk("exp_q_left",   32'(exp_q.size()),   32'd0);
        chk("grant_q_left", 32'(grant_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
